alu_req_arbiter: RTL and testbench

Shares the single complex-number ALU datapath between two command sources (requester 0 and requester 1). It accepts one operation at a time with round-robin priority and issues it to the ALU with a one-cycle start pulse. It waits for the ALU done flag under a programmable timeout, then returns the 64-bit result, or an error, to the requester that issued the operation. It sits between the command front-ends and the ALU/controller datapath and is the only block allowed to drive the ALU opcode and start.

---
 rtl/alu_req_arbiter_if.sv | 42 ++++
 rtl/alu_req_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_req_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_req_arbiter_if.sv
// Handshake bundle between the requesters, the ALU and the arbiter.
// The arbiter is the slave; requesters and ALU sit on the master side.
interface alu_req_arbiter_if #(
    parameter int DW = 64
);
    logic          req0_valid;
    logic [3:0]    req0_opr;
    logic          req0_ready;
    logic          req1_valid;
    logic [3:0]    req1_opr;
    logic          req1_ready;
    logic [3:0]    alu_opr;
    logic          alu_start;
    logic          alu_done;
    logic [DW-1:0] alu_result;
    logic          rsp0_valid;
    logic          rsp0_err;
    logic [DW-1:0] rsp0_data;
    logic          rsp1_valid;
    logic          rsp1_err;
    logic [DW-1:0] rsp1_data;

    modport slave (
        input  req0_valid, req0_opr,
        input  req1_valid, req1_opr,
        input  alu_done, alu_result,
        output req0_ready, req1_ready,
        output alu_opr, alu_start,
        output rsp0_valid, rsp0_err, rsp0_data,
        output rsp1_valid, rsp1_err, rsp1_data
    );

    modport master (
        output req0_valid, req0_opr,
        output req1_valid, req1_opr,
        output alu_done, alu_result,
        input  req0_ready, req1_ready,
        input  alu_opr, alu_start,
        input  rsp0_valid, rsp0_err, rsp0_data,
        input  rsp1_valid, rsp1_err, rsp1_data
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one complex ALU between two requesters,
// with start pulse, done timeout and per-requester response registers.
module alu_req_arbiter #(
    parameter int DW = 64
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [5:0]         maxclock_i,
    alu_req_arbiter_if.slave   bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          rr_q, rr_d;
    logic          own_q, own_d;
    logic [3:0]    opr_q, opr_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [5:0]    max_q, max_d;
    logic          err0_q, err1_q;
    logic [DW-1:0] data0_q, data1_q;

    logic          gnt0, gnt1;
    logic [3:0]    sel_opr;
    logic          legal;
    logic          wr_en;
    logic          wr_err;
    logic [DW-1:0] wr_data;

    // rr_q == 0 favours requester 0 on a tie
    assign gnt0 = bus.req0_valid & (~bus.req1_valid | ~rr_q);
    assign gnt1 = bus.req1_valid & (~bus.req0_valid | rr_q);
    assign sel_opr = gnt1 ? bus.req1_opr : bus.req0_opr;

    always_comb begin
        legal = 1'b0;
        case (sel_opr)
            4'b0000, 4'b0001, 4'b0010,
            4'b0011, 4'b0100, 4'b0110,
            4'b1000, 4'b1001, 4'b1010: legal = 1'b1;
            default:                   legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        own_d   = own_q;
        opr_d   = opr_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        wr_en   = 1'b0;
        wr_err  = 1'b0;
        wr_data = '0;
        unique case (state_q)
            S_IDLE: begin
                if (gnt0 | gnt1) begin
                    own_d = gnt1;
                    opr_d = sel_opr;
                    if (legal) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_RESP;
                        wr_en   = 1'b1;
                        wr_err  = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                max_d   = maxclock_i;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.alu_done) begin
                    state_d = S_RESP;
                    wr_en   = 1'b1;
                    wr_data = bus.alu_result;
                end else if (cnt_q == max_q) begin
                    state_d = S_RESP;
                    wr_en   = 1'b1;
                    wr_err  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_RESP: begin
                rr_d    = ~own_q;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            own_q   <= 1'b0;
            opr_q   <= '0;
            cnt_q   <= '0;
            max_q   <= '0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            data0_q <= '0;
            data1_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            own_q   <= own_d;
            opr_q   <= opr_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            if (wr_en && !own_d) begin
                err0_q  <= wr_err;
                data0_q <= wr_data;
            end
            if (wr_en && own_d) begin
                err1_q  <= wr_err;
                data1_q <= wr_data;
            end
        end
    end

    assign bus.req0_ready = (state_q == S_IDLE) & gnt0;
    assign bus.req1_ready = (state_q == S_IDLE) & gnt1;
    assign bus.alu_start  = (state_q == S_ISSUE);
    assign bus.alu_opr    = opr_q;
    assign bus.rsp0_valid = (state_q == S_RESP) & ~own_q;
    assign bus.rsp1_valid = (state_q == S_RESP) & own_q;
    assign bus.rsp0_err   = err0_q;
    assign bus.rsp1_err   = err1_q;
    assign bus.rsp0_data  = data0_q;
    assign bus.rsp1_data  = data1_q;
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: a small ALU model plus a
// response scoreboard checked on the falling clock edge.
module tb_alu_req_arbiter;
    localparam int DW = 64;

    typedef struct {
        int          who;
        logic        err;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  maxclock = 6'd10;

    alu_req_arbiter_if #(.DW(DW)) bus();

    alu_req_arbiter #(.DW(DW)) dut (
        .clock_i    (clock),
        .reset_i    (reset),
        .maxclock_i (maxclock),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sbq[$];

    always @(posedge clock) cyc <= cyc + 1;

    // ALU model: done arrives alu_delay cycles after start (0 = never)
    int          alu_delay = 0;
    int          pend = 0;
    bit          busy = 1'b0;
    int          n_start = 0;
    logic        model_done = 1'b0;
    logic        stray = 1'b0;
    logic [63:0] res_base = 64'h0;

    always @(negedge clock) begin
        if (reset) begin
            busy       <= 1'b0;
            model_done <= 1'b0;
        end else if (bus.alu_start) begin
            n_start    <= n_start + 1;
            pend       <= alu_delay;
            busy       <= (alu_delay > 0);
            model_done <= 1'b0;
        end else if (busy) begin
            if (pend == 1) begin
                model_done <= 1'b1;
                busy       <= 1'b0;
            end
            pend <= pend - 1;
        end else begin
            model_done <= 1'b0;
        end
    end

    assign bus.alu_done   = model_done | stray;
    assign bus.alu_result = res_base ^ {60'd0, bus.alu_opr};

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every response strobe must match the oldest expectation
    always @(negedge clock) begin
        if (bus.rsp0_valid || bus.rsp1_valid) begin
            if (sbq.size() == 0) begin
                chk("rsp_unexpected",
                    64'({bus.rsp1_valid, bus.rsp0_valid}), 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rsp_route",
                    64'({bus.rsp1_valid, bus.rsp0_valid}),
                    (e.who == 1) ? 64'd2 : 64'd1);
                chk("rsp_err",
                    64'((e.who == 1) ? bus.rsp1_err : bus.rsp0_err),
                    64'(e.err));
                chk("rsp_data",
                    (e.who == 1) ? bus.rsp1_data : bus.rsp0_data,
                    e.data);
                chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic wait_any(output int w, output int t);
        int n;
        n = 0;
        #1;
        while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("accept_seen",
            64'(bus.req0_ready | bus.req1_ready), 64'd1);
        chk("one_ready",
            64'(bus.req0_ready & bus.req1_ready), 64'd0);
        w = bus.req1_ready ? 1 : 0;
        t = cyc;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        chk("drain", 64'(sbq.size()), 64'd0);
    endtask

    // lat == 1 marks an illegal opcode (no ALU start expected)
    task automatic issue(input int who, input logic [3:0] op,
                         input int lat, input logic err,
                         input logic [63:0] data, input bit push);
        int w, t;
        exp_t e;
        if (who == 0) begin
            bus.req0_valid = 1'b1;
            bus.req0_opr   = op;
        end else begin
            bus.req1_valid = 1'b1;
            bus.req1_opr   = op;
        end
        wait_any(w, t);
        chk("grant_owner", 64'(w), 64'(who));
        if (push) begin
            e = '{who, err, data, t + lat};
            sbq.push_back(e);
        end
        @(negedge clock);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("start_pulse", 64'(bus.alu_start), (lat > 1) ? 64'd1 : 64'd0);
        if (lat > 1) chk("alu_opr", 64'(bus.alu_opr), 64'(op));
    endtask

    initial begin
        int   w, t, s0, exp_who;
        exp_t e;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_opr   = 4'd0;
        bus.req1_opr   = 4'd0;
        repeat (2) @(negedge clock);

        chk("rst_ready0", 64'(bus.req0_ready), 64'd0);
        chk("rst_ready1", 64'(bus.req1_ready), 64'd0);
        chk("rst_start", 64'(bus.alu_start), 64'd0);
        chk("rst_opr", 64'(bus.alu_opr), 64'd0);
        chk("rst_rsp0_err", 64'(bus.rsp0_err), 64'd0);
        chk("rst_rsp0_data", bus.rsp0_data, 64'd0);
        chk("rst_rsp1_data", bus.rsp1_data, 64'd0);
        reset = 1'b0;

        // simple sum, done two cycles after start
        res_base  = 64'h0000_0003_0000_0006;
        alu_delay = 2;
        maxclock  = 6'd10;
        issue(0, 4'b0010, 4, 1'b0, 64'h0000_0003_0000_0004, 1'b1);
        wait_empty();

        // both requesters always valid: grants alternate from rr=1
        res_base       = 64'hA5A5_0000_0000_1000;
        alu_delay      = 1;
        bus.req0_opr   = 4'b0100;
        bus.req1_opr   = 4'b0110;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        exp_who = 1;
        for (int i = 0; i < 4; i++) begin
            wait_any(w, t);
            chk("rr_grant", 64'(w), 64'(exp_who));
            e = '{w, 1'b0,
                  (w == 1) ? 64'hA5A5_0000_0000_1006
                           : 64'hA5A5_0000_0000_1004,
                  t + 3};
            sbq.push_back(e);
            @(negedge clock);
            if (i == 3) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            chk("alt_start", 64'(bus.alu_start), 64'd1);
            chk("alt_opr", 64'(bus.alu_opr),
                (w == 1) ? 64'd6 : 64'd4);
            exp_who = 1 - w;
        end
        wait_empty();

        // illegal opcode: immediate error, no ALU start
        #1 s0 = n_start;
        issue(1, 4'b0101, 1, 1'b1, 64'd0, 1'b1);
        wait_empty();
        repeat (2) @(negedge clock);
        #1 chk("illegal_no_start", 64'(n_start - s0), 64'd0);

        // timeout with maxclock=5, then done exactly on last WAIT cycle
        res_base  = 64'h1234_5678_0000_0000;
        maxclock  = 6'd5;
        alu_delay = 0;
        issue(0, 4'b0011, 8, 1'b1, 64'd0, 1'b1);
        wait_empty();
        alu_delay = 6;
        issue(0, 4'b0100, 8, 1'b0, 64'h1234_5678_0000_0004, 1'b1);
        wait_empty();
        maxclock  = 6'd0;
        alu_delay = 0;
        issue(1, 4'b0010, 3, 1'b1, 64'd0, 1'b1);
        wait_empty();

        // stray done while idle is ignored
        @(negedge clock);
        stray = 1'b1;
        @(negedge clock);
        stray = 1'b0;
        maxclock  = 6'd10;
        alu_delay = 3;
        issue(1, 4'b1010, 5, 1'b0, 64'h1234_5678_0000_000A, 1'b1);
        wait_empty();

        // leave rr at requester 1, then reset in the 3rd WAIT cycle
        alu_delay = 1;
        issue(0, 4'b1001, 3, 1'b0, 64'h1234_5678_0000_0009, 1'b1);
        wait_empty();
        alu_delay = 0;
        maxclock  = 6'd20;
        issue(0, 4'b0011, 10, 1'b0, 64'd0, 1'b0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_rsp0", 64'(bus.rsp0_valid), 64'd0);
        chk("mid_rst_rsp1", 64'(bus.rsp1_valid), 64'd0);
        chk("mid_rst_start", 64'(bus.alu_start), 64'd0);
        chk("mid_rst_opr", 64'(bus.alu_opr), 64'd0);
        chk("mid_rst_err0", 64'(bus.rsp0_err), 64'd0);
        chk("mid_rst_data0", bus.rsp0_data, 64'd0);
        chk("mid_rst_data1", bus.rsp1_data, 64'd0);
        reset = 1'b0;
        #1 s0 = n_start;
        alu_delay      = 1;
        bus.req0_opr   = 4'b0010;
        bus.req1_opr   = 4'b0001;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        wait_any(w, t);
        chk("rr_after_reset", 64'(w), 64'd0);
        e = '{0, 1'b0, 64'h1234_5678_0000_0002, t + 3};
        sbq.push_back(e);
        @(negedge clock);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("post_rst_start", 64'(bus.alu_start), 64'd1);
        wait_empty();
        repeat (2) @(negedge clock);
        #1 chk("post_rst_starts", 64'(n_start - s0), 64'd1);
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
